// File: rtl/fc_layer_engine.sv
// ---------------------------------------------------------------------------
// fc_layer_engine
//
// Fully-connected layer engine. For every output neuron it streams one input
// vector and one row of a row-major weight matrix out of two BRAMs (one cycle
// read latency), accumulates the signed fixed-point dot product, then writes
// the rescaled and saturated result to an output BRAM. Layer dimensions are
// latched from i_num_in / i_num_out when a run starts.
//
// Build option: define FC_RELU_EN to clamp negative results to zero after
// saturation. Without it the signed saturated value is written unchanged.
// Timing is the same in both builds.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   i_run                   start pulse (only looked at while idle)
//   i_num_in, i_num_out     inputs per neuron / number of neurons
//   o_idle, o_busy, o_done  status; o_done is a one-cycle pulse
//   ce_input, addr_input,   input vector BRAM read port
//   qout_input
//   ce_weight, addr_weight, weight matrix BRAM read port
//   qout_weight
//   ce_c, we_c, addr_c,     output BRAM write port
//   din_c
// ---------------------------------------------------------------------------
module fc_layer_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int WADDR_WIDTH = 17,
  parameter int ACC_WIDTH   = 48
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run,
  input  logic [ADDR_WIDTH-1:0]  i_num_in,
  input  logic [ADDR_WIDTH-1:0]  i_num_out,
  output logic                   o_idle,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   ce_input,
  output logic [ADDR_WIDTH-1:0]  addr_input,
  input  logic [DATA_WIDTH-1:0]  qout_input,
  output logic                   ce_weight,
  output logic [WADDR_WIDTH-1:0] addr_weight,
  input  logic [DATA_WIDTH-1:0]  qout_weight,
  output logic                   ce_c,
  output logic                   we_c,
  output logic [ADDR_WIDTH-1:0]  addr_c,
  output logic [DATA_WIDTH-1:0]  din_c
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0]        num_in_reg;
  logic [ADDR_WIDTH-1:0]        num_out_reg;
  logic [ADDR_WIDTH-1:0]        in_idx_reg;
  logic [ADDR_WIDTH-1:0]        out_idx_reg;
  logic [WADDR_WIDTH-1:0]       w_addr_reg;
  logic signed [ACC_WIDTH-1:0]  acc_reg;
  logic                         valid_reg;

  logic                         counts_ok;
  logic                         last_in;
  logic                         last_out;
  logic signed [PROD_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic [ACC_WIDTH-DATA_WIDTH:0] upper;
  logic                         fits;
  logic [DATA_WIDTH-1:0]        sat_value;
  logic [DATA_WIDTH-1:0]        result;

  assign counts_ok = (i_num_in != '0) && (i_num_out != '0);
  assign last_in   = (in_idx_reg == (num_in_reg - ADDR_WIDTH'(1)));
  assign last_out  = (out_idx_reg == (num_out_reg - ADDR_WIDTH'(1)));

  // Full-width signed product of the two BRAM words.
  assign product = PROD_WIDTH'($signed(qout_input)) * PROD_WIDTH'($signed(qout_weight));

  // Rescale to the output Q format (arithmetic shift = floor), then saturate:
  // the value fits when every bit from the output sign bit upward agrees.
  assign shifted = acc_reg >>> FRAC_BITS;
  assign upper   = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
  assign fits    = (&upper) | (~|upper);

  always_comb begin
    sat_value = shifted[DATA_WIDTH-1:0];
    if (!fits) begin
      if (shifted[ACC_WIDTH-1]) begin
        sat_value = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        sat_value = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end
  end

`ifdef FC_RELU_EN
  assign result = sat_value[DATA_WIDTH-1] ? '0 : sat_value;
`else
  assign result = sat_value;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and BRAM/status outputs
  always_comb begin
    state_next  = state_reg;
    o_idle      = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    ce_input    = 1'b0;
    ce_weight   = 1'b0;
    addr_input  = '0;
    addr_weight = '0;
    ce_c        = 1'b0;
    we_c        = 1'b0;
    addr_c      = '0;
    din_c       = '0;
    case (state_reg)
      S_IDLE: begin
        o_idle = 1'b1;
        o_busy = 1'b0;
        if (i_run) begin
          state_next = counts_ok ? S_MAC : S_DONE;
        end
      end
      S_MAC: begin
        ce_input    = 1'b1;
        ce_weight   = 1'b1;
        addr_input  = in_idx_reg;
        addr_weight = w_addr_reg;
        if (last_in) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_next = S_WRITE;
      end
      S_WRITE: begin
        ce_c       = 1'b1;
        we_c       = 1'b1;
        addr_c     = out_idx_reg;
        din_c      = result;
        state_next = last_out ? S_DONE : S_MAC;
      end
      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: counters, latched dimensions and the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_in_reg  <= '0;
      num_out_reg <= '0;
      in_idx_reg  <= '0;
      out_idx_reg <= '0;
      w_addr_reg  <= '0;
      acc_reg     <= '0;
      valid_reg   <= 1'b0;
    end else begin
      // Data returns one cycle after each issued read.
      valid_reg <= (state_reg == S_MAC);
      if (valid_reg) begin
        acc_reg <= acc_reg + {{(ACC_WIDTH-PROD_WIDTH){product[PROD_WIDTH-1]}}, product};
      end
      case (state_reg)
        S_IDLE: begin
          if (i_run) begin
            num_in_reg  <= i_num_in;
            num_out_reg <= i_num_out;
            in_idx_reg  <= '0;
            out_idx_reg <= '0;
            w_addr_reg  <= '0;
            acc_reg     <= '0;
          end
        end
        S_MAC: begin
          // w_addr keeps running across neurons: row o starts at o*num_in.
          in_idx_reg <= in_idx_reg + ADDR_WIDTH'(1);
          w_addr_reg <= w_addr_reg + WADDR_WIDTH'(1);
        end
        S_WRITE: begin
          acc_reg <= '0;
          if (!last_out) begin
            out_idx_reg <= out_idx_reg + ADDR_WIDTH'(1);
            in_idx_reg  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
module tb_fc_layer_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_run = 1'b0;
  logic [9:0]  i_num_in = '0;
  logic [9:0]  i_num_out = '0;
  logic        o_idle, o_busy, o_done;
  logic        ce_input, ce_weight, ce_c, we_c;
  logic [9:0]  addr_input, addr_c;
  logic [16:0] addr_weight;
  logic [15:0] qout_input = '0;
  logic [15:0] qout_weight = '0;
  logic [15:0] din_c;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] x_mem [0:1023];
  logic signed [15:0] w_mem [0:4095];

  // Logs gathered by run_layer (cycle 1 = first cycle after i_run is taken)
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int rd_waddr[$];
  int rd_iaddr[$];
  int rd_cyc[$];
  int done_cyc[$];
  int rd_both;
  int any_ce;
  int idle_at;

  always #5 clk = ~clk;

  // Single-read-latency BRAM models
  always @(posedge clk) begin
    if (ce_input)  qout_input  <= x_mem[addr_input];
    if (ce_weight) qout_weight <= w_mem[addr_weight];
  end

  fc_layer_engine dut (
    .clk(clk), .reset(reset), .i_run(i_run),
    .i_num_in(i_num_in), .i_num_out(i_num_out),
    .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done),
    .ce_input(ce_input), .addr_input(addr_input), .qout_input(qout_input),
    .ce_weight(ce_weight), .addr_weight(addr_weight), .qout_weight(qout_weight),
    .ce_c(ce_c), .we_c(we_c), .addr_c(addr_c), .din_c(din_c)
  );

  task automatic check(input string name, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // Reference: exact dot product, floor divide by 2^8, clamp to 16 bits.
  function automatic int ref_out(input int nin, input int o);
    longint acc = 0;
    for (int i = 0; i < nin; i++) begin
      acc += longint'(x_mem[i]) * longint'(w_mem[o*nin + i]);
    end
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`ifdef FC_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return int'(acc);
  endfunction

  function automatic logic signed [15:0] rnd_word(input bit big);
    if (big) return 16'($urandom_range(0, 65535));
    return 16'(int'($urandom_range(0, 1023)) - 512);
  endfunction

  // mode 0: plain run; 1: re-pulse i_run and change counts mid-run;
  // 2: assert reset during the MAC of neuron 1.
  task automatic run_layer(input int nin, input int nout, input int mode);
    bit finished = 0;
    int rc = nin + 4;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    rd_waddr.delete(); rd_iaddr.delete(); rd_cyc.delete(); done_cyc.delete();
    rd_both = 0; any_ce = 0; idle_at = -1;
    @(negedge clk);
    i_num_in = 10'(nin); i_num_out = 10'(nout); i_run = 1'b1;
    @(posedge clk);
    #1 i_run = 1'b0;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk);
      if (ce_input || ce_weight) begin
        rd_cyc.push_back(c);
        rd_waddr.push_back(int'(addr_weight));
        rd_iaddr.push_back(int'(addr_input));
        if (ce_input && ce_weight) rd_both++;
      end
      if (ce_input || ce_weight || ce_c || we_c) any_ce++;
      if (ce_c && we_c) begin
        wr_addr.push_back(int'(addr_c));
        wr_data.push_back(int'($signed(din_c)));
        wr_cyc.push_back(c);
      end
      if (o_done) done_cyc.push_back(c);
      if (mode == 1) begin
        if (c == 2) begin
          i_run = 1'b1; i_num_in = 10'(nin + 1); i_num_out = 10'(nout + 2);
        end else if (c == 3) begin
          i_run = 1'b0;
        end
      end
      if (mode == 2) begin
        if (c == rc) begin
          reset = 1'b1;
        end else if (c == rc + 1) begin
          check("rst_mid_idle", int'(o_idle), 1);
          check("rst_mid_busy", int'(o_busy), 0);
          check("rst_mid_ce", int'(ce_input | ce_weight | ce_c | we_c), 0);
          reset = 1'b0;
        end
        if (c == rc + 8) begin
          finished = 1;
          break;
        end
      end else begin
        if (done_cyc.size() > 0 && o_idle && idle_at < 0) idle_at = c;
        if (idle_at > 0 && c >= idle_at + 3) begin
          finished = 1;
          break;
        end
      end
    end
    check("run_terminated", int'(finished), 1);
  endtask

  task automatic verify(input string tag, input int nin, input int nout);
    int eff  = (nin == 0 || nout == 0) ? 0 : nout;
    int dexp = (eff == 0) ? 1 : nout * (nin + 2) + 1;
    check({tag, "_nwrites"}, wr_addr.size(), eff);
    for (int o = 0; o < eff && o < wr_addr.size(); o++) begin
      check($sformatf("%s_wr%0d_addr", tag, o), wr_addr[o], o);
      check($sformatf("%s_wr%0d_data", tag, o), wr_data[o], ref_out(nin, o));
      check($sformatf("%s_wr%0d_cyc", tag, o), wr_cyc[o], (o + 1) * (nin + 2));
    end
    check({tag, "_nreads"}, rd_cyc.size(), nin * eff);
    check({tag, "_ce_pair"}, rd_both, rd_cyc.size());
    for (int k = 0; k < nin * eff && k < rd_cyc.size(); k++) begin
      check($sformatf("%s_rd%0d_waddr", tag, k), rd_waddr[k], k);
      check($sformatf("%s_rd%0d_iaddr", tag, k), rd_iaddr[k], k % nin);
      check($sformatf("%s_rd%0d_cyc", tag, k), rd_cyc[k], (k / nin) * (nin + 2) + (k % nin) + 1);
    end
    check({tag, "_ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) check({tag, "_done_cyc"}, done_cyc[0], dexp);
    check({tag, "_idle_cyc"}, idle_at, dexp + 1);
  endtask

  initial begin
    int nin, nout;
    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_idle", int'(o_idle), 1);
    check("reset_busy", int'(o_busy), 0);
    check("reset_done", int'(o_done), 0);
    check("reset_ce", int'(ce_input | ce_weight | ce_c | we_c), 0);
    check("reset_addr", int'(addr_input) + int'(addr_weight) + int'(addr_c), 0);
    check("reset_din", int'(din_c), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", int'(o_idle), 1);

    // ---- 2x2 directed layer
    x_mem[0] = 16'sd256; x_mem[1] = 16'sd512;
    w_mem[0] = 16'sd256; w_mem[1] = 16'sd256; w_mem[2] = -16'sd256; w_mem[3] = 16'sd128;
    run_layer(2, 2, 0);
    verify("l2x2", 2, 2);
    if (wr_data.size() >= 2) begin
      check("l2x2_y0", wr_data[0], 768);
      check("l2x2_y1", wr_data[1], 0);
    end

    // ---- 3x2 timing with random data
    for (int i = 0; i < 3; i++) x_mem[i] = rnd_word(0);
    for (int i = 0; i < 6; i++) w_mem[i] = rnd_word(0);
    run_layer(3, 2, 0);
    verify("l3x2", 3, 2);

    // ---- saturation
    x_mem[0] = 16'sd32767; w_mem[0] = 16'sd32767;
    run_layer(1, 1, 0);
    verify("sat_pos", 1, 1);
    if (wr_data.size() >= 1) check("sat_pos_val", wr_data[0], 32767);
    w_mem[0] = -16'sd32768;
    run_layer(1, 1, 0);
    verify("sat_neg", 1, 1);
`ifdef FC_RELU_EN
    if (wr_data.size() >= 1) check("sat_neg_val", wr_data[0], 0);
`else
    if (wr_data.size() >= 1) check("sat_neg_val", wr_data[0], -32768);
`endif

    // ---- zero counts
    run_layer(0, 5, 0);
    verify("zero_in", 0, 5);
    check("zero_in_no_ce", any_ce, 0);
    run_layer(4, 0, 0);
    verify("zero_out", 4, 0);
    check("zero_out_no_ce", any_ce, 0);

    // ---- random layers, mixing small and full-range operands
    for (int t = 0; t < 6; t++) begin
      nin  = int'($urandom_range(1, 12));
      nout = int'($urandom_range(1, 6));
      for (int i = 0; i < nin; i++) x_mem[i] = rnd_word(t[0]);
      for (int i = 0; i < nin * nout; i++) w_mem[i] = rnd_word(t[0]);
      run_layer(nin, nout, 0);
      verify($sformatf("rnd%0d", t), nin, nout);
    end

    // ---- reset in the middle of neuron 1 of 4, then a clean rerun
    for (int i = 0; i < 5; i++) x_mem[i] = rnd_word(0);
    for (int i = 0; i < 20; i++) w_mem[i] = rnd_word(0);
    run_layer(5, 4, 2);
    check("rst_nwrites", wr_addr.size(), 1);
    check("rst_ndone", done_cyc.size(), 0);
    if (wr_data.size() >= 1) check("rst_wr0_data", wr_data[0], ref_out(5, 0));
    run_layer(5, 4, 0);
    verify("after_rst", 5, 4);

    // ---- i_run re-pulsed and counts changed while busy
    for (int i = 0; i < 3; i++) x_mem[i] = rnd_word(1);
    for (int i = 0; i < 9; i++) w_mem[i] = rnd_word(1);
    run_layer(3, 3, 1);
    verify("repulse", 3, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
